// File: rtl/damage_controller_if.sv
// Player damage/heal bus between the game logic and damage_controller.
// master drives requests and strobes; slave is the controller itself.
interface damage_controller_if;
    logic       tick;
    logic [3:0] dmg_req;
    logic [7:0] dmg_amt;
    logic       heal_req;
    logic [1:0] heal_amt;
    logic [3:0] dmg_ack;
    logic [3:0] health;
    logic       invincible;
    logic       blink;
    logic       hit_pulse;
    logic       game_over;

    modport master (
        output tick, dmg_req, dmg_amt, heal_req, heal_amt,
        input  dmg_ack, health, invincible, blink, hit_pulse, game_over
    );

    modport slave (
        input  tick, dmg_req, dmg_amt, heal_req, heal_amt,
        output dmg_ack, health, invincible, blink, hit_pulse, game_over
    );
endinterface

// File: rtl/damage_controller.sv
// Player health FSM: round-robin damage arbitration, invincibility window, death.
// Define DAMAGE_CTRL_HEAL_EN to let heal_req/heal_amt restore health.
module damage_controller #(
    parameter int INIT_HEALTH = 3,
    parameter int MAX_HEALTH  = 7,
    parameter int INV_TICKS   = 64
) (
    input logic                 clk,
    input logic                 reset,
    damage_controller_if.slave  bus
);

    localparam logic [1:0] ALIVE  = 2'd0;
    localparam logic [1:0] INVULN = 2'd1;
    localparam logic [1:0] DEAD   = 2'd2;

    logic [1:0] state;
    logic [3:0] health;
    logic [1:0] rr;
    logic [7:0] counter;
    logic [3:0] dmg_ack;
    logic       hit_pulse;

    logic [3:0] elig;
    logic       grant_vld;
    logic [1:0] grant_idx;
    logic [1:0] grant_amt;
    logic [1:0] idx;
    logic [3:0] hit_health;

    always_comb begin
        elig = '0;
        for (int i = 0; i < 4; i++) begin
            elig[i] = bus.dmg_req[i] && (bus.dmg_amt[2*i +: 2] != 2'b00);
        end
    end

    // First eligible requester at or after rr, wrapping 3 -> 0.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = rr;
        idx       = rr;
        for (int k = 0; k < 4; k++) begin
            idx = rr + 2'(k);
            if (!grant_vld && elig[idx]) begin
                grant_vld = 1'b1;
                grant_idx = idx;
            end
        end
    end

    always_comb begin
        grant_amt  = bus.dmg_amt[{grant_idx, 1'b0} +: 2];
        hit_health = (health > {2'b00, grant_amt})
                   ? health - {2'b00, grant_amt}
                   : 4'd0;
    end

`ifdef DAMAGE_CTRL_HEAL_EN
    logic [4:0] heal_sum;
    logic [3:0] heal_health;

    always_comb begin
        heal_sum    = {1'b0, health} + {3'b000, bus.heal_amt};
        heal_health = (heal_sum > 5'(MAX_HEALTH))
                    ? 4'(MAX_HEALTH)
                    : heal_sum[3:0];
    end
`else
    logic heal_unused;
    assign heal_unused = ^{bus.heal_req, bus.heal_amt};
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ALIVE;
            health    <= 4'(INIT_HEALTH);
            rr        <= 2'd0;
            counter   <= 8'd0;
            dmg_ack   <= 4'd0;
            hit_pulse <= 1'b0;
        end else begin
            dmg_ack   <= 4'd0;
            hit_pulse <= 1'b0;
            case (state)
                ALIVE: begin
                    if (grant_vld) begin
                        health    <= hit_health;
                        dmg_ack   <= 4'b0001 << grant_idx;
                        hit_pulse <= 1'b1;
                        rr        <= grant_idx + 2'd1;
                        if (hit_health != 4'd0) begin
                            state   <= INVULN;
                            counter <= 8'(INV_TICKS);
                        end else begin
                            state <= DEAD;
                        end
                    end
`ifdef DAMAGE_CTRL_HEAL_EN
                    // A heal coinciding with a granted hit is dropped.
                    else if (bus.heal_req) begin
                        health <= heal_health;
                    end
`endif
                end
                INVULN: begin
                    if (bus.tick) begin
                        if (counter == 8'd1) begin
                            state   <= ALIVE;
                            counter <= 8'd0;
                        end else begin
                            counter <= counter - 8'd1;
                        end
                    end
`ifdef DAMAGE_CTRL_HEAL_EN
                    if (bus.heal_req) begin
                        health <= heal_health;
                    end
`endif
                end
                DEAD: begin
                    health <= 4'd0;
                end
                default: begin
                    state <= ALIVE;
                end
            endcase
        end
    end

    assign bus.dmg_ack    = dmg_ack;
    assign bus.hit_pulse  = hit_pulse;
    assign bus.health     = health;
    assign bus.invincible = (state == INVULN);
    assign bus.blink      = (state == INVULN) && counter[2];
    assign bus.game_over  = (state == DEAD);

endmodule

// File: tb/tb_damage_controller.sv
// Directed bench for damage_controller: vector table on a fast-invuln
// instance plus hand sequences on a default instance.
module tb_damage_controller;

    logic clk;
    logic rst_a;
    logic rst_b;

    damage_controller_if a_if ();
    damage_controller_if b_if ();

    damage_controller dut_a (
        .clk   (clk),
        .reset (rst_a),
        .bus   (a_if.slave)
    );

    damage_controller #(
        .INIT_HEALTH (7),
        .MAX_HEALTH  (7),
        .INV_TICKS   (1)
    ) dut_b (
        .clk   (clk),
        .reset (rst_b),
        .bus   (b_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       tick;
        logic [3:0] req;
        logic [7:0] amt;
        logic [3:0] ack;
        logic [3:0] health;
        logic       inv;
        logic       hit;
        logic       go;
    } vec_t;

    vec_t tbl [14];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic a_set(input logic r, input logic t, input logic [3:0] q,
                         input logic [7:0] m, input logic hq,
                         input logic [1:0] ha);
        rst_a          = r;
        a_if.tick      = t;
        a_if.dmg_req   = q;
        a_if.dmg_amt   = m;
        a_if.heal_req  = hq;
        a_if.heal_amt  = ha;
    endtask

    task automatic chk_a(input string name, input logic [3:0] ack,
                         input logic [3:0] h, input logic inv,
                         input logic bl, input logic hit, input logic go);
        chk({name, ".ack"}, 32'(a_if.dmg_ack), 32'(ack));
        chk({name, ".health"}, 32'(a_if.health), 32'(h));
        chk({name, ".inv"}, 32'(a_if.invincible), 32'(inv));
        chk({name, ".blink"}, 32'(a_if.blink), 32'(bl));
        chk({name, ".hit"}, 32'(a_if.hit_pulse), 32'(hit));
        chk({name, ".go"}, 32'(a_if.game_over), 32'(go));
    endtask

    initial begin
        // rst tick req amt | ack health inv hit go
        tbl[0]  = '{1'b1, 1'b0, 4'h0, 8'h00, 4'h0, 4'd7, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 1'b1, 4'hF, 8'h55, 4'h1, 4'd6, 1'b1, 1'b1, 1'b0};
        tbl[2]  = '{1'b0, 1'b1, 4'hF, 8'h55, 4'h0, 4'd6, 1'b0, 1'b0, 1'b0};
        tbl[3]  = '{1'b0, 1'b1, 4'hF, 8'h55, 4'h2, 4'd5, 1'b1, 1'b1, 1'b0};
        tbl[4]  = '{1'b0, 1'b1, 4'hF, 8'h55, 4'h0, 4'd5, 1'b0, 1'b0, 1'b0};
        tbl[5]  = '{1'b0, 1'b1, 4'hF, 8'h55, 4'h4, 4'd4, 1'b1, 1'b1, 1'b0};
        tbl[6]  = '{1'b0, 1'b1, 4'hF, 8'h55, 4'h0, 4'd4, 1'b0, 1'b0, 1'b0};
        tbl[7]  = '{1'b0, 1'b1, 4'hF, 8'h55, 4'h8, 4'd3, 1'b1, 1'b1, 1'b0};
        tbl[8]  = '{1'b0, 1'b1, 4'hF, 8'h55, 4'h0, 4'd3, 1'b0, 1'b0, 1'b0};
        tbl[9]  = '{1'b0, 1'b1, 4'hF, 8'h55, 4'h1, 4'd2, 1'b1, 1'b1, 1'b0};
        tbl[10] = '{1'b0, 1'b1, 4'hF, 8'h55, 4'h0, 4'd2, 1'b0, 1'b0, 1'b0};
        // requester 1 asks with zero amount: not eligible, 2 wins
        tbl[11] = '{1'b0, 1'b1, 4'h6, 8'h20, 4'h4, 4'd0, 1'b0, 1'b1, 1'b1};
        tbl[12] = '{1'b0, 1'b1, 4'hF, 8'hFF, 4'h0, 4'd0, 1'b0, 1'b0, 1'b1};
        tbl[13] = '{1'b1, 1'b0, 4'h0, 8'h00, 4'h0, 4'd7, 1'b0, 1'b0, 1'b0};

        a_set(1'b1, 1'b0, 4'h0, 8'h00, 1'b0, 2'd0);
        rst_b         = 1'b1;
        b_if.tick     = 1'b0;
        b_if.dmg_req  = 4'h0;
        b_if.dmg_amt  = 8'h00;
        b_if.heal_req = 1'b0;
        b_if.heal_amt = 2'd0;

        for (int v = 0; v < 14; v++) begin
            rst_b        = tbl[v].rst;
            b_if.tick    = tbl[v].tick;
            b_if.dmg_req = tbl[v].req;
            b_if.dmg_amt = tbl[v].amt;
            step();
            chk($sformatf("vec%0d.ack", v), 32'(b_if.dmg_ack), 32'(tbl[v].ack));
            chk($sformatf("vec%0d.health", v), 32'(b_if.health), 32'(tbl[v].health));
            chk($sformatf("vec%0d.inv", v), 32'(b_if.invincible), 32'(tbl[v].inv));
            chk($sformatf("vec%0d.hit", v), 32'(b_if.hit_pulse), 32'(tbl[v].hit));
            chk($sformatf("vec%0d.go", v), 32'(b_if.game_over), 32'(tbl[v].go));
            chk($sformatf("vec%0d.blink", v), 32'(b_if.blink), 32'd0);
        end
        rst_b = 1'b1;

        a_set(1'b1, 1'b0, 4'h0, 8'h00, 1'b0, 2'd0);
        step();
        chk_a("reset", 4'h0, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0);

        a_set(1'b0, 1'b0, 4'h1, 8'h01, 1'b0, 2'd0);
        step();
        chk_a("first_hit", 4'h1, 4'd2, 1'b1, 1'b0, 1'b1, 1'b0);

        // 64 ticks, requests held throughout must all be ignored
        for (int k = 1; k <= 64; k++) begin
            a_set(1'b0, 1'b1, 4'hF, 8'hFF, 1'b0, 2'd0);
            step();
            if (k < 64)
                chk_a($sformatf("tick%0d", k), 4'h0, 4'd2, 1'b1,
                      1'(((64 - k) >> 2) & 1), 1'b0, 1'b0);
            else
                chk_a("tick64", 4'h0, 4'd2, 1'b0, 1'b0, 1'b0, 1'b0);
            if (k < 64) begin
                a_set(1'b0, 1'b0, 4'hF, 8'hFF, 1'b0, 2'd0);
                step();
                chk_a($sformatf("idle%0d", k), 4'h0, 4'd2, 1'b1,
                      1'(((64 - k) >> 2) & 1), 1'b0, 1'b0);
            end
        end

        a_set(1'b0, 1'b0, 4'h2, 8'h04, 1'b0, 2'd0);
        step();
        chk_a("grant_after_inv", 4'h2, 4'd1, 1'b1, 1'b0, 1'b1, 1'b0);

        a_set(1'b0, 1'b1, 4'h0, 8'h00, 1'b0, 2'd0);
        repeat (64) step();
        chk_a("inv_exit", 4'h0, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0);

        a_set(1'b0, 1'b0, 4'h4, 8'h30, 1'b0, 2'd0);
        step();
        chk_a("death", 4'h4, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1);

        a_set(1'b0, 1'b1, 4'hF, 8'hFF, 1'b1, 2'd3);
        step();
        chk_a("dead_hold", 4'h0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        step();
        chk_a("dead_hold2", 4'h0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);

        a_set(1'b1, 1'b0, 4'h0, 8'h00, 1'b0, 2'd0);
        step();
        chk_a("revive", 4'h0, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0);

        a_set(1'b0, 1'b0, 4'h1, 8'h01, 1'b0, 2'd0);
        step();
        chk_a("mid_hit", 4'h1, 4'd2, 1'b1, 1'b0, 1'b1, 1'b0);
        a_set(1'b0, 1'b1, 4'h0, 8'h00, 1'b0, 2'd0);
        repeat (34) step();
        chk_a("cnt30", 4'h0, 4'd2, 1'b1, 1'b1, 1'b0, 1'b0);
        a_set(1'b1, 1'b1, 4'hF, 8'hFF, 1'b1, 2'd3);
        step();
        chk_a("mid_reset", 4'h0, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0);

        a_set(1'b0, 1'b0, 4'h0, 8'h00, 1'b1, 2'd3);
        step();
`ifdef DAMAGE_CTRL_HEAL_EN
        chk_a("heal1", 4'h0, 4'd6, 1'b0, 1'b0, 1'b0, 1'b0);
`else
        chk_a("heal1", 4'h0, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0);
`endif
        step();
`ifdef DAMAGE_CTRL_HEAL_EN
        chk_a("heal_sat", 4'h0, 4'd7, 1'b0, 1'b0, 1'b0, 1'b0);
`else
        chk_a("heal_sat", 4'h0, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0);
`endif
        a_set(1'b0, 1'b0, 4'h1, 8'h01, 1'b1, 2'd3);
        step();
`ifdef DAMAGE_CTRL_HEAL_EN
        chk_a("heal_and_hit", 4'h1, 4'd6, 1'b1, 1'b0, 1'b1, 1'b0);
`else
        chk_a("heal_and_hit", 4'h1, 4'd2, 1'b1, 1'b0, 1'b1, 1'b0);
`endif

        a_set(1'b1, 1'b0, 4'h0, 8'h00, 1'b0, 2'd0);
        step();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/damage_controller.md
DAMAGE_CONTROLLER -- requirements
Module: damage_controller

Interface
REQ-001 Parameter INIT_HEALTH, default 3: health value loaded at reset, legal range 1..MAX_HEALTH.
REQ-002 Parameter MAX_HEALTH, default 7: saturation ceiling for health, legal range 1..15.
REQ-003 Parameter INV_TICKS, default 64: invincibility length in tick strobes, legal range 1..255.
REQ-004 clk  input  1  system clock; all state SHALL change on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 tick  input  1  one-cycle strobe from the game timer that sets the invincibility time base.
REQ-007 dmg_req  input  4  level-sensitive damage request, one bit per requester (slime, spike, projectile, boss).
REQ-008 dmg_amt  input  8  damage amount, 2 bits per requester; requester i uses bits [2i+1:2i].
REQ-009 heal_req  input  1  one-cycle heal pulse.
REQ-010 heal_amt  input  2  heal amount.
REQ-011 dmg_ack  output  4  registered one-hot grant, high for one cycle.
REQ-012 health  output  4  current health.
REQ-013 invincible  output  1  high while in INVULN.
REQ-014 blink  output  1  sprite blink enable.
REQ-015 hit_pulse  output  1  one-cycle pulse on every applied hit.
REQ-016 game_over  output  1  high in DEAD.

Function
REQ-017 FSM states SHALL be ALIVE, INVULN and DEAD.
REQ-018 Requester i is eligible only when dmg_req[i]=1 and its dmg_amt field is non-zero.
REQ-019 In ALIVE, when one or more requesters are eligible in cycle N, the block SHALL grant exactly one of them by round-robin, starting the search at pointer rr and wrapping 3->0.
REQ-020 At the edge ending cycle N the block SHALL: decrease health by the granted amount, saturating at 0; pulse dmg_ack[i] and hit_pulse for one cycle; and set rr to (i+1) mod 4.
REQ-021 If the new health is non-zero, the FSM SHALL enter INVULN and load the counter with INV_TICKS.
REQ-022 If the new health is 0, the FSM SHALL enter DEAD.
REQ-023 In INVULN, requests SHALL be ignored: no ack, no health change, and rr is held.
REQ-024 In INVULN, the counter SHALL decrement on each tick; a tick seen with counter=1 SHALL return the FSM to ALIVE with counter=0.
REQ-025 A request in the first ALIVE cycle after INVULN SHALL be granted normally.
REQ-026 blink SHALL equal counter bit 2 while in INVULN and 0 in every other state.
REQ-027 tick SHALL have no effect in ALIVE or DEAD.
REQ-028 DEAD SHALL persist until reset: game_over=1, health=0, every request and heal ignored.
REQ-029 Requests deasserted before being granted SHALL be dropped; there is no queuing.

Reset
REQ-030 When reset=1, the block SHALL set: state=ALIVE, health=INIT_HEALTH, rr=0, counter=0, and dmg_ack, hit_pulse, invincible, blink, game_over all 0.
REQ-031 Reset SHALL take priority over all other inputs in the same cycle, including mid-INVULN and in DEAD.

Configuration
REQ-032 Macro DAMAGE_CTRL_HEAL_EN defined: in ALIVE or INVULN, heal_req=1 SHALL add heal_amt to health, saturating at MAX_HEALTH, one cycle later.
REQ-033 With DAMAGE_CTRL_HEAL_EN defined, a heal in the same cycle as a granted hit SHALL be dropped; the hit applies alone.
REQ-034 With DAMAGE_CTRL_HEAL_EN defined, a heal SHALL NOT change the state or the counter.
REQ-035 Macro undefined: heal_req and heal_amt SHALL remain ports but be ignored, and health never increases except at reset.

Verification
REQ-036 Reset, then dmg_req=0001, amt0=1 for one cycle -> next cycle: dmg_ack=0001, hit_pulse=1, health=2, invincible=1.
REQ-037 Continue with 64 tick strobes -> invincible falls after the 64th; blink toggles every 4 ticks; further requests in between produce no ack.
REQ-038 dmg_req=1111, all amts=1, held with INV_TICKS=1 and tick every cycle, starting from health 7 -> grants in order 0,1,2,3,0; health stepping 6,5,4,3,2.
REQ-039 Health=1, dmg amt=3 -> health=0, game_over=1, no INVULN; a later heal_req or dmg_req leaves health at 0; reset restores health=3, game_over=0.
REQ-040 HEAL_EN, health=6, heal_amt=3 -> health=7 (saturated); heal_req and a dmg grant (amt 1) in the same cycle -> health=6.
REQ-041 Reset asserted mid-INVULN at counter=30 -> next cycle: state ALIVE, invincible=0, blink=0, health=INIT_HEALTH.
